// File: rtl/fp_norm_scheduler.sv
// Shared normalization stage for the FFT butterfly: round-robin arbitration between the
// sum and difference adders, then LZC/shift/exponent-adjust into packed IEEE-754 single words.
module fp_norm_scheduler #(
    parameter int EXP_W = 8,
    parameter int SIG_W = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_sign,
    input  logic [2*EXP_W-1:0]        req_exp,
    input  logic [2*(SIG_W+1)-1:0]    req_sig,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+SIG_W-1:0]    out_data,
    output logic                      out_id
);

    localparam int MANT_W  = SIG_W - 1;
    localparam int LZC_W   = $clog2(SIG_W);
    localparam int E9_W    = EXP_W + 1;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // A producer may drop valid without a transfer; ready never waits on a future valid.
    // req_ready is combinational from req_valid/out_ready; out_* are registered and held
    // stable while out_valid & !out_ready.

    logic                last_grant;
    logic [1:0]          grant;
    logic                advance1;
    logic                advance2;
    logic                accept;
    logic                accept_id;

    logic                s1_valid;
    logic                s1_sign;
    logic [EXP_W-1:0]    s1_exp;
    logic [SIG_W:0]      s1_sig;
    logic                s1_id;

    logic                sel_sign;
    logic [EXP_W-1:0]    sel_exp;
    logic [SIG_W:0]      sel_sig;

    logic [LZC_W-1:0]    lzc;
    logic [E9_W-1:0]     exp9;
    logic [E9_W-1:0]     sum9;
    logic [E9_W-1:0]     diff9;
    logic [MANT_W-1:0]   shifted;
    logic                norm_sign;
    logic [EXP_W-1:0]    norm_exp;
    logic [MANT_W-1:0]   norm_mant;
    logic [EXP_W+SIG_W-1:0] norm_data;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign advance2  = !out_valid || out_ready;
    assign advance1  = !s1_valid || advance2;
    assign req_ready = rst ? 2'b00 : (grant & {2{advance1}});
    assign accept    = |(req_valid & req_ready);
    assign accept_id = req_ready[1];

    assign sel_sign = accept_id ? req_sign[1] : req_sign[0];
    assign sel_exp  = accept_id ? req_exp[2*EXP_W-1:EXP_W] : req_exp[EXP_W-1:0];
    assign sel_sig  = accept_id ? req_sig[2*(SIG_W+1)-1:SIG_W+1] : req_sig[SIG_W:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_sig     <= '0;
            s1_id      <= 1'b0;
            last_grant <= 1'b1;
        end else if (advance1) begin
            s1_valid <= accept;
            if (accept) begin
                s1_sign    <= sel_sign;
                s1_exp     <= sel_exp;
                s1_sig     <= sel_sig;
                s1_id      <= accept_id;
                last_grant <= accept_id;
            end
        end
    end

    // Leading-zero count over the significand (carry bit excluded); the MSB assignment wins.
    always_comb begin
        lzc = '0;
        for (int i = 0; i < SIG_W; i++) begin
            if (s1_sig[i]) lzc = LZC_W'(SIG_W - 1 - i);
        end
    end

    // Nine-bit exponent math: carry path can overflow to infinity, the shift path
    // underflows when exp - lzc borrows or lands on zero.
    always_comb begin
        exp9      = {1'b0, s1_exp};
        sum9      = exp9 + E9_W'(1);
        diff9     = exp9 - E9_W'(lzc);
        shifted   = MANT_W'(s1_sig[SIG_W-1:0] << lzc);
        norm_sign = s1_sign;
        norm_exp  = '0;
        norm_mant = '0;
        if (s1_sig[SIG_W]) begin
            if (sum9 >= E9_W'(EXP_MAX)) begin
                norm_exp  = EXP_W'(EXP_MAX);
                norm_mant = '0;
            end else begin
                norm_exp  = sum9[EXP_W-1:0];
                norm_mant = s1_sig[SIG_W-1:1];
            end
        end else if (s1_sig[SIG_W-1:0] == '0) begin
            norm_sign = 1'b0;
        end else if (diff9[EXP_W] || (diff9[EXP_W-1:0] == '0)) begin
            norm_exp  = '0;
            norm_mant = '0;
        end else begin
            norm_exp  = diff9[EXP_W-1:0];
            norm_mant = shifted;
        end
        norm_data = {norm_sign, norm_exp, norm_mant};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 1'b0;
        end else if (advance2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= norm_data;
                out_id   <= s1_id;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_scheduler.sv
// Directed bench for fp_norm_scheduler: accepted requests push hand-computed results into
// a queue, and a monitor pops and compares every result the block hands downstream.
module tb_fp_norm_scheduler;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [24:0] g;
        logic [31:0] x;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_sign;
    logic [15:0] req_exp;
    logic [49:0] req_sig;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_id;

    logic [32:0] exp_q[$];
    logic [32:0] exp_e;
    logic [31:0] cur_exp [2];
    vec_t        v0 [7];
    vec_t        v1 [7];
    int          i0, i1, lim0, lim1;
    int          n_checks = 0;
    int          n_errors = 0;

    fp_norm_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sign  (req_sign),
        .req_exp   (req_exp),
        .req_sig   (req_sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    // Accept tracker: a transfer seen at the negedge lands on the following posedge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) exp_q.push_back({logic'(i), cur_exp[i]});
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL out_unexpected: got id=%0d data=%08h, required no output", out_id, out_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({out_id, out_data} !== exp_e) begin
                    n_errors++;
                    $display("FAIL out_result: got id=%0d data=%08h, required id=%0d data=%08h",
                             out_id, out_data, exp_e[32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic load(input int r, input vec_t v);
        req_sign[r] = v.s;
        if (r == 0) begin
            req_exp[7:0]  = v.e;
            req_sig[24:0] = v.g;
        end else begin
            req_exp[15:8]  = v.e;
            req_sig[49:25] = v.g;
        end
        cur_exp[r]   = v.x;
        req_valid[r] = 1'b1;
    endtask

    // One cycle of the two-requester driver; a granted requester moves to its next vector.
    task automatic pump(output logic acc, output logic id, output logic ov);
        @(negedge clk);
        acc = |(req_valid & req_ready);
        id  = req_ready[1];
        ov  = out_valid;
        @(posedge clk);
        #1;
        if (acc) begin
            if (!id) begin
                i0++;
                if (i0 < lim0) load(0, v0[i0]);
                else req_valid[0] = 1'b0;
            end else begin
                i1++;
                if (i1 < lim1) load(1, v1[i1]);
                else req_valid[1] = 1'b0;
            end
        end
    endtask

    task automatic pump_out();
        logic a, d, o;
        int t = 0;
        while ((i0 < lim0 || i1 < lim1) && t < 20) begin
            pump(a, d, o);
            t++;
        end
        chk("pump_done", 64'(i0 >= lim0 && i1 >= lim1), 64'd1);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 64'(exp_q.size() == 0 && !out_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input logic s, input logic [7:0] e, input logic [24:0] g,
                        input logic [31:0] x);
        vec_t v;
        int t = 0;
        v = '{s, e, g, x};
        load(r, v);
        @(negedge clk);
        while (!req_ready[r] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_accept", 64'(req_ready[r]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
    endtask

    initial begin
        logic acc, id, ov;
        logic [31:0] hold;
        int n_acc;

        v0[0] = '{1'b0, 8'd127, 25'h0800000, 32'h3F800000};
        v0[1] = '{1'b0, 8'd127, 25'h1000000, 32'h40000000};
        v0[2] = '{1'b1, 8'd127, 25'h0C00000, 32'hBFC00000};
        v0[3] = '{1'b0, 8'd23,  25'h0000001, 32'h00000000};
        v0[4] = '{1'b0, 8'd24,  25'h0000001, 32'h00800000};
        v0[5] = '{1'b0, 8'd127, 25'h0800000, 32'h3F800000};
        v0[6] = '{1'b1, 8'd127, 25'h1000000, 32'hC0000000};
        v1[0] = '{1'b0, 8'd127, 25'h0000001, 32'h34000000};
        v1[1] = '{1'b0, 8'd130, 25'h0001234, 32'h3B91A000};
        v1[2] = '{1'b0, 8'd100, 25'h1800001, 32'h32C00000};
        v1[3] = '{1'b1, 8'd10,  25'h0000001, 32'h80000000};
        v1[4] = '{1'b1, 8'd100, 25'h0000000, 32'h00000000};
        v1[5] = '{1'b0, 8'd127, 25'h0000001, 32'h34000000};
        v1[6] = '{1'b0, 8'd130, 25'h0001234, 32'h3B91A000};

        rst       = 1'b1;
        out_ready = 1'b1;
        req_valid = 2'b00;
        req_sign  = 2'b00;
        req_exp   = '0;
        req_sig   = '0;
        cur_exp[0] = '0;
        cur_exp[1] = '0;

        // Reset state, with both requesters already asking
        i0 = 0; i1 = 0; lim0 = 3; lim1 = 3;
        load(0, v0[0]);
        load(1, v1[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_id",    64'(out_id),    64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Continuous tie: grants alternate from requester 0, one result per cycle
        for (int k = 0; k < 6; k++) begin
            pump(acc, id, ov);
            chk("arb_accept", 64'(acc), 64'd1);
            chk("arb_grant", 64'(id), 64'(k % 2));
            if (k >= 2) chk("arb_out_valid", 64'(ov), 64'd1);
        end
        for (int k = 0; k < 2; k++) begin
            pump(acc, id, ov);
            chk("arb_out_tail", 64'(ov), 64'd1);
        end
        drain();

        // Single request latency: result visible two negedges after the accepting one
        load(0, v0[0]);
        n_acc = 0;
        @(negedge clk);
        while (!req_ready[0] && n_acc < 20) begin
            @(negedge clk);
            n_acc++;
        end
        chk("lat_accept", 64'(req_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("lat_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_data",  64'(out_data),  64'h3F800000);
        chk("lat_id",    64'(out_id),    64'd0);
        drain();

        // Directed normalization vectors
        send(1, 1'b0, 8'd127, 25'h0000001, 32'h34000000);
        send(0, 1'b0, 8'd254, 25'h1000000, 32'h7F800000);
        send(0, 1'b0, 8'd255, 25'h1000000, 32'h7F800000);
        send(1, 1'b1, 8'd100, 25'h0000000, 32'h00000000);
        send(0, 1'b0, 8'd10,  25'h0000001, 32'h00000000);
        send(1, 1'b0, 8'd0,   25'h0800000, 32'h00000000);
        send(0, 1'b1, 8'd127, 25'h1800001, 32'hC0400000);
        send(1, 1'b0, 8'd130, 25'h0001234, 32'h3B91A000);
        drain();

        // Backpressure: two accepts fill both stages, then the block stalls with data held
        i0 = 3; i1 = 3; lim0 = 5; lim1 = 5;
        load(0, v0[3]);
        load(1, v1[3]);
        out_ready = 1'b0;
        n_acc = 0;
        hold = '0;
        for (int k = 0; k < 5; k++) begin
            pump(acc, id, ov);
            if (acc) n_acc++;
            if (k < 2) chk("bp_fill", 64'(acc), 64'd1);
            else chk("bp_stall_ready", 64'(req_ready), 64'd0);
            if (k == 1) hold = out_data;
            if (k >= 2) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_data", 64'(out_data), 64'(hold));
            end
        end
        chk("bp_accepts", 64'(n_acc), 64'd2);
        out_ready = 1'b1;
        pump_out();
        drain();

        // Reset with both stages full; last winner before reset is requester 0
        i0 = 5; i1 = 5; lim0 = 7; lim1 = 7;
        out_ready = 1'b0;
        load(1, v1[5]);
        pump(acc, id, ov);
        chk("pre_rst_r1", 64'({acc, id}), 64'b11);
        load(0, v0[5]);
        pump(acc, id, ov);
        chk("pre_rst_r0", 64'({acc, id}), 64'b10);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data",  64'(out_data),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        pump(acc, id, ov);
        chk("tie_after_rst", 64'({acc, id}), 64'b10);
        pump_out();
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
